// File: rtl/conflict_finder_pkg.sv
// Shared crossbar definitions: the destination index width used by every crossbar block.
package conflict_finder_pkg;

   function automatic int dest_width(input int m_count);
      return (m_count > 1) ? $clog2(m_count) : 1;
   endfunction

endpackage

// File: rtl/conflict_finder_dest_decoder.sv
// One-hot decode of a destination master index; out-of-range indices decode to all-zero.
module dest_decoder
   import conflict_finder_pkg::*;
#(
   parameter int M_DATA_COUNT = 3,
   localparam int T_DEST_WIDTH = dest_width(M_DATA_COUNT)
) (
   input  logic [T_DEST_WIDTH-1:0] dest,
   output logic [M_DATA_COUNT-1:0] hit
);

   always_comb begin
      hit = '0;
      for (int m = 0; m < M_DATA_COUNT; m++) begin
         if (dest == T_DEST_WIDTH'(m)) hit[m] = 1'b1;
      end
   end

endmodule

// File: rtl/conflict_finder.sv
// Flags every master port targeted by two or more slave ports in the same cycle.
// Output is registered (one cycle latency) and cleared asynchronously by rst_n.
module conflict_finder
   import conflict_finder_pkg::*;
#(
   parameter int S_DATA_COUNT = 2,
   parameter int M_DATA_COUNT = 3,
   localparam int T_DEST_WIDTH = dest_width(M_DATA_COUNT)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [T_DEST_WIDTH-1:0] s_dest_i [S_DATA_COUNT-1:0],
   output logic [M_DATA_COUNT-1:0] conflict_o
);

   logic [M_DATA_COUNT-1:0] hit [S_DATA_COUNT-1:0];
   logic [M_DATA_COUNT-1:0] conflict_next;

   for (genvar s = 0; s < S_DATA_COUNT; s++) begin : g_dec
      dest_decoder #(
         .M_DATA_COUNT(M_DATA_COUNT)
      ) u_dest_decoder (
         .dest(s_dest_i[s]),
         .hit (hit[s])
      );
   end

   // "At least two of S": remember whether any earlier slave already hit this master.
   for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_reduce
      logic seen_one;
      logic seen_two;

      always_comb begin
         seen_one = 1'b0;
         seen_two = 1'b0;
         for (int s = 0; s < S_DATA_COUNT; s++) begin
            seen_two = seen_two | (seen_one & hit[s][m]);
            seen_one = seen_one | hit[s][m];
         end
      end

      assign conflict_next[m] = seen_two;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_o <= '0;
      end else begin
         conflict_o <= conflict_next;
      end
   end

endmodule

// File: tb/tb_conflict_finder.sv
// Bench for conflict_finder (S=2, M=3) plus a single-slave instance that must never flag.
module tb_conflict_finder;

   localparam int S = 2;
   localparam int M = 3;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] s_dest [S-1:0];
   logic [M-1:0] conflict;
   logic [W-1:0] s_dest_one [0:0];
   logic [M-1:0] conflict_one;

   int compared = 0;
   int mismatched = 0;
   logic [M-1:0] exp_q [$];

   always #5 clk = ~clk;

   conflict_finder #(
      .S_DATA_COUNT(S),
      .M_DATA_COUNT(M)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_dest_i  (s_dest),
      .conflict_o(conflict)
   );

   assign s_dest_one[0] = s_dest[0];

   conflict_finder #(
      .S_DATA_COUNT(1),
      .M_DATA_COUNT(M)
   ) dut_one (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_dest_i  (s_dest_one),
      .conflict_o(conflict_one)
   );

   function automatic logic [M-1:0] model(input logic [W-1:0] d0, input logic [W-1:0] d1);
      logic [M-1:0] r;
      int cnt;
      r = '0;
      for (int m = 0; m < M; m++) begin
         cnt = 0;
         if (int'(d0) == m) cnt++;
         if (int'(d1) == m) cnt++;
         r[m] = (cnt >= 2);
      end
      return r;
   endfunction

   // Drive mid-cycle, queue the expectation, compare one rising edge later.
   task automatic apply(input string name, input logic [W-1:0] d0, input logic [W-1:0] d1);
      logic [M-1:0] exp;
      @(negedge clk);
      s_dest[0] = d0;
      s_dest[1] = d1;
      exp_q.push_back(model(d0, d1));
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      compared++;
      if (conflict !== exp) begin
         mismatched++;
         $display("FAIL %s: conflict_o got %b expected %b", name, conflict, exp);
      end
      compared++;
      if (conflict_one !== '0) begin
         mismatched++;
         $display("FAIL %s_single_slave: conflict_o got %b expected 000", name, conflict_one);
      end
   endtask

   task automatic test_reset();
      s_dest[0] = 2'd0;
      s_dest[1] = 2'd0;
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if (conflict !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_async: conflict_o got %b expected 000", conflict);
      end
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if (conflict !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_held: conflict_o got %b expected 000", conflict);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_distinct();
      apply("dist_0_1", 2'd0, 2'd1);
      apply("dist_2_1", 2'd2, 2'd1);
      apply("dist_2_0", 2'd2, 2'd0);
   endtask

   task automatic test_shared();
      apply("shared_1_1", 2'd1, 2'd1);
      apply("shared_2_2", 2'd2, 2'd2);
      apply("shared_0_0", 2'd0, 2'd0);
   endtask

   task automatic test_out_of_range();
      apply("oor_3_3", 2'd3, 2'd3);
      apply("oor_3_0", 2'd3, 2'd0);
      apply("oor_0_3", 2'd0, 2'd3);
   endtask

   task automatic test_back_to_back();
      apply("lat_0_1", 2'd0, 2'd1);
      // Output must still show the old value between the input change and the edge.
      @(negedge clk);
      s_dest[0] = 2'd1;
      s_dest[1] = 2'd1;
      exp_q.push_back(model(2'd1, 2'd1));
      #1;
      compared++;
      if (conflict !== 3'b000) begin
         mismatched++;
         $display("FAIL lat_hold: conflict_o got %b expected 000", conflict);
      end
      @(posedge clk);
      #1;
      compared++;
      if (conflict !== exp_q.pop_front()) begin
         mismatched++;
         $display("FAIL lat_1_1: conflict_o got %b expected 010", conflict);
      end
      apply("lat_back_0_1", 2'd0, 2'd1);
   endtask

   task automatic test_reset_mid();
      apply("mid_1_1", 2'd1, 2'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      compared++;
      if (conflict !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_mid_async: conflict_o got %b expected 000", conflict);
      end
      @(posedge clk);
      #1;
      compared++;
      if (conflict !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_mid_held: conflict_o got %b expected 000", conflict);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      compared++;
      if (conflict !== 3'b010) begin
         mismatched++;
         $display("FAIL reset_release_first_edge: conflict_o got %b expected 010", conflict);
      end
   endtask

   initial begin
      test_reset();
      test_distinct();
      test_shared();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/conflict_finder.md
# conflict_finder

Combinational destination-collision detector with a registered output for the stream crossbar. Each slave (input) port presents the index of the master (output) port it targets. The block flags every master port that two or more slave ports target in the same cycle. The crossbar arbiter uses these flags to decide where arbitration is needed.

## Interface
Parameters:
- `S_DATA_COUNT`, default 2: number of slave (input) ports; legal range ≥ 1.
- `M_DATA_COUNT`, default 3: number of master (output) ports; legal range ≥ 2.
- `T_DEST_WIDTH`, localparam = `$clog2(M_DATA_COUNT)`: width of one destination index.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `s_dest_i`  in  `[T_DEST_WIDTH-1:0]` × `[S_DATA_COUNT-1:0]` (unpacked array)  destination master index requested by each slave port.
- `conflict_o`  out  `[M_DATA_COUNT-1:0]`  bit m = 1 when two or more slave ports target master m.

## Operation
- Decode each `s_dest_i[s]` to a one-hot vector `hit[s][M_DATA_COUNT-1:0]`.
- A destination value ≥ `M_DATA_COUNT` is out of range. It decodes to all-zero and takes part in no conflict.
- For each master m, count the slave ports with `hit[s][m]=1`.
- Next value of `conflict_o[m]` = (count ≥ 2). This is equivalent to an "at least two of S" reduction and needs no adder wider than required.
- `S_DATA_COUNT = 1`: `conflict_o` is constantly 0 after reset.
- No valid qualifier exists. Every slave port counts as requesting every cycle, including the destination index 0.
- Several masters may be flagged at once. Example: with 4 slaves, dests {0,0,1,1} → `conflict_o` = `0011`.
- Output bits are independent. A conflict on one master does not affect the others.

## Timing
- `conflict_o` is registered, with 1-cycle latency. A value applied to `s_dest_i` before rising edge N appears on `conflict_o` after edge N and holds until edge N+1.
- Reset: asserting `rst_n`=0 clears `conflict_o` to all-zero immediately, without waiting for a clock edge. It stays zero while reset is held.
- First update after release is on the first rising edge with `rst_n`=1. That edge already reflects the current `s_dest_i`.
- Reset asserted mid-operation discards the pending result. No state other than the output register exists.
- No handshake, no backpressure, no multi-cycle states.
- Inputs must be stable during setup/hold around the rising edge. Changes between edges have no effect until the next edge.

## Structure
- Shared crossbar package: `T_DEST_WIDTH` derivation (a `dest_width(M)` function or equivalent). Other crossbar blocks reuse the same index width.
- One natural sub-module: `dest_decoder`, parameterized by `M_DATA_COUNT`, with `T_DEST_WIDTH` in and `M_DATA_COUNT` one-hot out. Out-of-range input gives all-zero output. Instantiate it `S_DATA_COUNT` times in a generate loop.
- Top level holds:
  - a per-master "≥2 of S" reduction (generate loop over m);
  - the output register with async clear.

## Test plan
S_DATA_COUNT=2, M_DATA_COUNT=3, clock period 10. Stimulus changes mid-cycle; check after the next rising edge.
- Reset held, dests {0,0} → `conflict_o`=`000` while `rst_n`=0 (async clear verified before any clock edge).
- dests {0,1} → `000`; then {2,1} → `000`. Distinct targets never flag.
- dests {1,1} → `010`; {2,2} → `100`; {0,0} → `001`. Exactly the shared master is flagged.
- Out of range: dests {3,3} → `000`. Dests {3,0} → `000`.
- Latency: switch {0,1} → {1,1} → {0,1} on consecutive cycles. `conflict_o` reads `000`, `010`, `000`, each one edge after its input. Assert `rst_n`=0 while the output is `010` → `000` immediately.
